// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, fetches words over a req/ack bus, feeds IF/ID.
// Latency: one cycle from accepted ack to if_* (one instruction per cycle on back-to-back acks).
// Backpressure: stall_i parks one in-flight word in a skid entry and drops req; jump_i flushes.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    input  logic        stall_i,
    input  logic        jump_i,
    input  logic [31:0] jump_addr_i,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        if_valid
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        SKID  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    // Address of the request still outstanding when a redirect arrived mid-fetch.
    logic [31:0] drain_addr, drain_addr_n;
    logic [31:0] skid_pc, skid_pc_n;
    logic [31:0] skid_inst, skid_inst_n;
    logic [31:0] if_pc_n, if_inst_n;
    logic        if_valid_n;
    logic        accept;

    // Request is live in FETCH and DRAIN; it drops immediately while reset is held.
    assign ibus_req  = !rst && (state != SKID);
    // In DRAIN the bus keeps the old address until its ack, even though pc already holds the target.
    assign ibus_addr = (state == DRAIN) ? drain_addr : pc;
    assign accept    = ibus_req && ibus_ack;

    // Next-state, PC, skid and IF/ID output logic; a redirect overrides stall and ack data.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        drain_addr_n = drain_addr;
        skid_pc_n    = skid_pc;
        skid_inst_n  = skid_inst;
        if_pc_n      = if_pc;
        if_inst_n    = if_inst;
        if_valid_n   = if_valid;
        if (jump_i) begin
            if_pc_n    = 32'h0;
            if_inst_n  = NOP_INST;
            if_valid_n = 1'b0;
            pc_n       = {jump_addr_i[31:2], 2'b00};
            // A fetch still in flight must be drained before the target is requested.
            if (state == FETCH && !accept) begin
                state_n      = DRAIN;
                drain_addr_n = pc;
            end else if (state == DRAIN && !accept) begin
                state_n = DRAIN;
            end else begin
                state_n = FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (accept) begin
                        pc_n = pc + 32'd4;
                        if (stall_i) begin
                            skid_pc_n   = pc;
                            skid_inst_n = ibus_rdata;
                            state_n     = SKID;
                        end else begin
                            if_pc_n    = pc;
                            if_inst_n  = ibus_rdata;
                            if_valid_n = 1'b1;
                        end
                    end
                end
                SKID: begin
                    if (!stall_i) begin
                        if_pc_n    = skid_pc;
                        if_inst_n  = skid_inst;
                        if_valid_n = 1'b1;
                        state_n    = FETCH;
                    end
                end
                DRAIN: begin
                    if (accept) begin
                        state_n = FETCH;
                    end
                end
                default: begin
                    state_n = FETCH;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            drain_addr <= 32'h0;
            skid_pc    <= 32'h0;
            skid_inst  <= 32'h0;
            if_pc      <= 32'h0;
            if_inst    <= 32'h0;
            if_valid   <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            drain_addr <= drain_addr_n;
            skid_pc    <= skid_pc_n;
            skid_inst  <= skid_inst_n;
            if_pc      <= if_pc_n;
            if_inst    <= if_inst_n;
            if_valid   <= if_valid_n;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios followed by randomized stall/jump/ack/reset traffic.
// The presented instruction stream is checked against a program-order model (pc+4, redirects).
// Memory returns addr ^ 32'hA5A5_0000; junk is driven on rdata whenever ack is low.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] MEM_KEY  = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack = 1'b0;
    logic [31:0] ibus_rdata = 32'h0;
    logic        stall_i = 1'b0;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = 32'h0;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;

    int n_cmp = 0;
    int n_bad = 0;

    // Redirects (jump targets and reset PC) in issue order; the stream model takes the newest.
    logic [31:0] redir_q[$];

    logic        pend_rst = 1'b0;
    logic        pend_jump = 1'b0;
    logic [31:0] pend_target = 32'h0;
    int          wait_cnt = 0;

    inst_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst),
        .ibus_req(ibus_req), .ibus_addr(ibus_addr),
        .ibus_ack(ibus_ack), .ibus_rdata(ibus_rdata),
        .stall_i(stall_i), .jump_i(jump_i), .jump_addr_i(jump_addr_i),
        .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One bus cycle: drive at negedge, answer the request combinationally, return at negedge+3.
    // ack_mode: 0 never ack, 1 ack whenever requested, 2 random ack with bounded wait.
    task automatic cyc(input logic r, input logic s, input logic j, input logic [31:0] ja,
                       input int ack_mode);
        logic a;
        @(negedge clk);
        if (pend_rst) redir_q.push_back(RESET_PC);
        else if (pend_jump) redir_q.push_back(pend_target);
        rst         = r;
        stall_i     = s;
        jump_i      = j;
        jump_addr_i = ja;
        pend_rst    = r;
        pend_jump   = j;
        pend_target = {ja[31:2], 2'b00};
        #1;
        case (ack_mode)
            0:       a = 1'b0;
            1:       a = ibus_req;
            default: a = ibus_req && (($urandom % 3) != 0 || wait_cnt >= 3);
        endcase
        ibus_ack   = a;
        ibus_rdata = a ? (ibus_addr ^ MEM_KEY) : $urandom;
        if (ibus_req && !a) wait_cnt++;
        else wait_cnt = 0;
        #2;
    endtask

    // Monitor: protocol, hold and flush rules, plus the presented stream against program order.
    initial begin
        logic        p_rst, p_stall, p_jump, p_req, p_ack, p_valid;
        logic [31:0] p_addr, p_pc, p_inst, exp_pc;
        int          idle;
        p_rst = 1'b1; p_stall = 1'b0; p_jump = 1'b0; p_req = 1'b0; p_ack = 1'b0;
        p_valid = 1'b0; p_addr = 32'h0; p_pc = 32'h0; p_inst = 32'h0;
        exp_pc = RESET_PC; idle = 0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (!p_rst) begin
                    if (p_stall && !p_jump) begin
                        chk("hold_pc", if_pc, p_pc);
                        chk("hold_inst", if_inst, p_inst);
                        chk("hold_valid", {31'b0, if_valid}, {31'b0, p_valid});
                    end
                    if (p_jump) begin
                        chk("flush_valid", {31'b0, if_valid}, 32'h0);
                        chk("flush_inst", if_inst, NOP_INST);
                        chk("flush_pc", if_pc, 32'h0);
                    end
                    if (p_req && !p_ack) begin
                        chk("req_held", {31'b0, ibus_req}, 32'h1);
                        chk("addr_stable", ibus_addr, p_addr);
                    end
                end
                if (ibus_req) chk("addr_align", {30'b0, ibus_addr[1:0]}, 32'h0);
                if (if_valid && (!p_valid || if_pc != p_pc)) begin
                    if (redir_q.size() > 0) begin
                        exp_pc = redir_q[$];
                        redir_q.delete();
                    end
                    chk("stream_pc", if_pc, exp_pc);
                    chk("stream_inst", if_inst, exp_pc ^ MEM_KEY);
                    exp_pc = exp_pc + 32'd4;
                    idle = 0;
                end else if (stall_i || jump_i) begin
                    idle = 0;
                end else begin
                    idle++;
                    if (idle > 40) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL progress: %0d idle cycles without a new instruction, limit 40", idle);
                        idle = 0;
                    end
                end
            end else begin
                idle = 0;
            end
            p_rst = rst; p_stall = stall_i; p_jump = jump_i; p_req = ibus_req; p_ack = ibus_ack;
            p_addr = ibus_addr; p_pc = if_pc; p_inst = if_inst; p_valid = if_valid;
        end
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        // Reset state
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("rst_req", {31'b0, ibus_req}, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);

        // Streaming: request on the first cycle out of reset, one instruction per cycle
        cyc(0, 0, 0, 0, 1);
        chk("t1_req", {31'b0, ibus_req}, 32'h1);
        chk("t1_addr", ibus_addr, RESET_PC);
        cyc(0, 0, 0, 0, 1);
        chk("t1_pc0", if_pc, 32'h0);
        chk("t1_inst0", if_inst, 32'h0 ^ MEM_KEY);
        chk("t1_valid", {31'b0, if_valid}, 32'h1);
        cyc(0, 0, 0, 0, 1);
        chk("t1_pc4", if_pc, 32'h4);
        cyc(0, 0, 0, 0, 1);
        chk("t1_pc8", if_pc, 32'h8);

        // Stall as ack for 0x10 arrives: skid, req drops, release later
        cyc(0, 1, 0, 0, 1);
        chk("t2_addr", ibus_addr, 32'h10);
        cyc(0, 1, 0, 0, 1);
        chk("t2_req_low", {31'b0, ibus_req}, 32'h0);
        chk("t2_hold_pc", if_pc, 32'hC);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t2_pc", if_pc, 32'h10);
        chk("t2_inst", if_inst, 32'h10 ^ MEM_KEY);
        chk("t2_next_addr", ibus_addr, 32'h14);

        // Jump while a request is outstanding: old address held until its ack
        cyc(0, 0, 1, 32'h203, 0);
        cyc(0, 0, 0, 0, 0);
        chk("t3_valid", {31'b0, if_valid}, 32'h0);
        chk("t3_nop", if_inst, NOP_INST);
        chk("t3_drain_addr", ibus_addr, 32'h14);
        cyc(0, 0, 0, 0, 0);
        chk("t3_drain_addr2", ibus_addr, 32'h14);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t3_target", ibus_addr, 32'h200);
        chk("t3_discard", {31'b0, if_valid}, 32'h0);

        // Jump and ack in the same cycle
        cyc(0, 0, 1, 32'h100, 1);
        cyc(0, 0, 0, 0, 0);
        chk("t4_target", ibus_addr, 32'h100);
        chk("t4_valid", {31'b0, if_valid}, 32'h0);

        // PC wrap at the top of the address space
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("t5_top", if_pc, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);
        chk("t5_wrap", if_pc, 32'h0);

        // Jump with stall while the skid entry is full
        cyc(0, 1, 0, 0, 1);
        cyc(0, 1, 1, 32'h40, 0);
        chk("t6_skid_req", {31'b0, ibus_req}, 32'h0);
        cyc(0, 0, 0, 0, 0);
        chk("t6_valid", {31'b0, if_valid}, 32'h0);
        chk("t6_req", {31'b0, ibus_req}, 32'h1);
        chk("t6_addr", ibus_addr, 32'h40);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, j;
            logic [31:0] ja;
            r  = ($urandom % 400) == 0;
            s  = ($urandom % 10) < 3;
            j  = ($urandom % 25) == 0;
            ja = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            cyc(r, s, j, ja, 2);
        end
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
